dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port word-addressed data memory (1024 x 32).
//  Shares it between port 0 (CPU load/store) and port 1 (DMA/debug): one access per cycle,
//  round-robin grant, optional locked bursts. Read data is returned registered, one cycle after grant.
// PARAMETERS
//  ADDR_W     32    requester/memory address width (word index)
//  DATA_W     32    data width
//  DEPTH      1024  number of valid memory words; addr >= DEPTH is out of range
//  MAX_BURST  4     max consecutive grants to a locking owner (>=1)
// PORTS
//  clk_i        in   1       clock, all state on posedge
//  rst_i        in   1       asynchronous, active-low reset
//  reqN_i       in   1       N=0,1: access request; hold addr/we/wdata/lock stable until gntN_o
//  addrN_i      in   ADDR_W  word address
//  weN_i        in   1       1=write, 0=read
//  wdataN_i     in   DATA_W  write data
//  lockN_i      in   1       request to keep ownership for the next beat (burst)
//  gntN_o       out  1       combinational grant; access takes effect at this clock edge
//  rvalidN_o    out  1       one-cycle pulse, cycle after a granted access (read or write)
//  rdataN_o     out  DATA_W  read data, valid with rvalidN_o (0 for writes/errors)
//  errN_o       out  1       with rvalidN_o: access was out of range
//  mem_addr_o   out  ADDR_W  to memory addr_i
//  mem_we_o     out  1       to memory MemWrite_i
//  mem_wdata_o  out  DATA_W  to memory data_i
//  mem_rdata_i  in   DATA_W  from memory data_o (combinational read)
// BEHAVIOUR
//  - Reset (rst_i=0, async): state=ARB, last=1 (port 0 wins first), beat_cnt=0, rvalid*=0, rdata*=0,
//    err*=0; gnt*, mem_we_o forced 0 while in reset. Reset mid-burst abandons the burst; no partial write.
//  - At most one gnt per cycle. mem_* driven from granted port; idle: mem_addr_o=0, mem_we_o=0, wdata=0.
//  - States: ARB, BURST0, BURST1.
//    ARB: one requester -> grant it; both -> grant port != last. On grant: last<=granted.
//      If granted lockN_i=1 and MAX_BURST>1 -> BURSTN, beat_cnt<=1; else stay ARB.
//    BURSTN: if reqN_i=1: grant N only (other port waits), beat_cnt++ ;
//      exit to ARB when lockN_i=0 or beat_cnt+1==MAX_BURST (forced release; last=N so other port wins next).
//      if reqN_i=0: behave as ARB this cycle (other port may be granted), leave burst.
//  - Read: mem_rdata_i sampled at grant edge -> rdataN_o, rvalidN_o=1 next cycle; latency 1.
//  - Write: memory commits at grant edge; rvalidN_o=1, rdataN_o=0 next cycle (write ack).
//  - Out of range (addrN_i >= DEPTH): still granted; mem_we_o=0, mem_addr_o=0; next cycle rvalidN_o=1,
//    errN_o=1, rdataN_o=0. Memory unchanged.
//  - Back-to-back write then read same address (any ports) returns new data (write lands first edge).
//  - Requester dropping reqN_i without grant is legal; no state change.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs gnt_cnt0_o, gnt_cnt1_o, conflict_cnt_o (32 b each):
//   per-port grant counts and cycles where both req high but one not granted; reset to 0 async,
//   saturate at 32'hFFFF_FFFF. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  1. Preload mem[5]=32'hDEAD_BEEF; port0 read addr 5 -> gnt0_o same cycle, next cycle rvalid0_o=1,
//     rdata0_o=32'hDEAD_BEEF, err0_o=0.
//  2. Both ports request reads continuously, lock=0 -> grants 0,1,0,1,... ; never both gnt high.
//  3. MAX_BURST=4, port1 lock=1 holding req, port0 req=1 -> four consecutive gnt1_o, then gnt0_o.
//  4. Port0 write 32'h1234_5678 @10, next cycle port1 read @10 -> rdata1_o=32'h1234_5678.
//  5. Port0 write addr 1024 -> mem_we_o=0, next cycle rvalid0_o=1, err0_o=1; mem[0] unchanged.
//  6. Assert rst_i low during beat 2 of a port1 burst -> gnt*/rvalid* drop immediately; after release
//     with both requesting, port0 granted first. With DMEM_ARB_STATS_EN, test 2 over 10 cycles
//     -> gnt_cnt0_o=5, gnt_cnt1_o=5, conflict_cnt_o=10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter/sequencer in front of a single-port, word-addressed data
// memory with combinational read. Port 0 is the CPU load/store port and port 1
// is the DMA/debug port.
//
// Behaviour summary:
//   - One memory access per cycle. Grants alternate between ports when both
//     request.
//   - A granted port may hold its lock input to keep ownership for up to
//     MAX_BURST consecutive beats.
//   - Every granted access gets a registered response one cycle later.
//     - Reads return the memory data.
//     - Writes return 0 as an acknowledge.
//     - Out-of-range accesses return 0 with err set and never touch memory.
//
// Optional feature macro: DMEM_ARB_STATS_EN
//   When defined, the block adds saturating 32-bit grant and conflict counters
//   on the ports gnt_cnt0_o, gnt_cnt1_o and conflict_cnt_o.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   reqN_i/addrN_i/weN_i/
//   wdataN_i/lockN_i               requester N (N = 0, 1) request bundle
//   gntN_o                         combinational grant (access happens at
//                                  this clock edge)
//   rvalidN_o/rdataN_o/errN_o      registered response, one cycle after
//                                  the grant
//   mem_addr_o/mem_we_o/
//   mem_wdata_o                    memory command
//   mem_rdata_i                    memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // requester 0 (CPU)
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              we0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              lock0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              err0_o,
    // requester 1 (DMA / debug)
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              we1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              lock1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err1_o,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       gnt_cnt0_o,
    output logic [31:0]       gnt_cnt1_o,
    output logic [31:0]       conflict_cnt_o,
`endif
    // memory side
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    // beat_cnt value at which the current grant is the last allowed beat
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST0 = 2'd1,
        ST_BURST1 = 2'd2
    } state_e;

    // Address range check shared by both ports
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return (addr >= DEPTH_A);
    endfunction

    state_e            state_r;
    logic              last_r;       // index of the most recently granted port
    logic [CNT_W-1:0]  beat_cnt_r;

    logic              rvalid0_r;
    logic              rvalid1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic              err0_r;
    logic              err1_r;

    logic              gnt0_s;
    logic              gnt1_s;
    logic              gnt_any_s;
    logic              burst_hold_s; // burst owner is requesting and keeps the slot
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_we_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_lock_s;
    logic              oor_s;
    state_e            arb_state_s;
    logic [CNT_W-1:0]  arb_beat_s;

    // Grant selection: burst owner first, otherwise round-robin on last_r
    always_comb begin
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        burst_hold_s = 1'b0;
        if (!rst_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if ((state_r == ST_BURST0) && req0_i) begin
            gnt0_s       = 1'b1;
            burst_hold_s = 1'b1;
        end else if ((state_r == ST_BURST1) && req1_i) begin
            gnt1_s       = 1'b1;
            burst_hold_s = 1'b1;
        end else if (req0_i && req1_i) begin
            // last_r == 1 means port 1 went last, so port 0 wins now
            gnt0_s = last_r;
            gnt1_s = ~last_r;
        end else begin
            // A burst owner that dropped its request falls through to here,
            // which lets the other port use the slot this cycle.
            gnt0_s = req0_i;
            gnt1_s = req1_i;
        end
    end

    assign gnt_any_s   = gnt0_s | gnt1_s;
    assign sel_addr_s  = gnt1_s ? addr1_i  : addr0_i;
    assign sel_we_s    = gnt1_s ? we1_i    : we0_i;
    assign sel_wdata_s = gnt1_s ? wdata1_i : wdata0_i;
    assign sel_lock_s  = gnt1_s ? lock1_i  : lock0_i;
    assign oor_s       = out_of_range(sel_addr_s);

    // Memory command: the bus stays all-zero when idle or out of range
    always_comb begin
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_we_o    = 1'b0;
        mem_wdata_o = {DATA_W{1'b0}};
        if (gnt_any_s && !oor_s) begin
            mem_addr_o  = sel_addr_s;
            mem_we_o    = sel_we_s;
            mem_wdata_o = sel_we_s ? sel_wdata_s : {DATA_W{1'b0}};
        end else begin
            mem_addr_o  = {ADDR_W{1'b0}};
            mem_we_o    = 1'b0;
            mem_wdata_o = {DATA_W{1'b0}};
        end
    end

    // Next state for a plain arbitration cycle (used from ARB and from a
    // burst state whose owner has dropped its request)
    always_comb begin
        arb_state_s = ST_ARB;
        arb_beat_s  = {CNT_W{1'b0}};
        if (gnt_any_s && sel_lock_s && (MAX_BURST > 1)) begin
            arb_state_s = gnt1_s ? ST_BURST1 : ST_BURST0;
            arb_beat_s  = CNT_W'(1);
        end else begin
            arb_state_s = ST_ARB;
            arb_beat_s  = {CNT_W{1'b0}};
        end
    end

    // Sequencer state and registered responses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_ARB;
            last_r     <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            rdata0_r   <= {DATA_W{1'b0}};
            rdata1_r   <= {DATA_W{1'b0}};
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
        end else begin
            rvalid0_r <= gnt0_s;
            rvalid1_r <= gnt1_s;
            err0_r    <= gnt0_s & oor_s;
            err1_r    <= gnt1_s & oor_s;
            rdata0_r  <= (gnt0_s && !sel_we_s && !oor_s) ? mem_rdata_i : {DATA_W{1'b0}};
            rdata1_r  <= (gnt1_s && !sel_we_s && !oor_s) ? mem_rdata_i : {DATA_W{1'b0}};

            if (gnt_any_s) begin
                last_r <= gnt1_s;
            end else begin
                last_r <= last_r;
            end

            case (state_r)
                ST_BURST0, ST_BURST1: begin
                    if (burst_hold_s) begin
                        // Release on lock drop or once MAX_BURST beats are done;
                        // last_r already points at the owner so the other port
                        // wins the next contested cycle.
                        if (!sel_lock_s || (beat_cnt_r == BEAT_LAST)) begin
                            state_r    <= ST_ARB;
                            beat_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            state_r    <= state_r;
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r    <= arb_state_s;
                        beat_cnt_r <= arb_beat_s;
                    end
                end
                ST_ARB: begin
                    state_r    <= arb_state_s;
                    beat_cnt_r <= arb_beat_s;
                end
                default: begin
                    state_r    <= ST_ARB;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign gnt0_o    = gnt0_s;
    assign gnt1_o    = gnt1_s;
    assign rvalid0_o = rvalid0_r;
    assign rvalid1_o = rvalid1_r;
    assign rdata0_o  = rdata0_r;
    assign rdata1_o  = rdata1_r;
    assign err0_o    = err0_r;
    assign err1_o    = err1_r;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0_r;
    logic [31:0] gnt_cnt1_r;
    logic [31:0] conflict_cnt_r;
    logic        conflict_s;

    assign conflict_s = req0_i & req1_i & ~(gnt0_s & gnt1_s);

    // Saturating grant / conflict statistics
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_cnt0_r     <= 32'd0;
            gnt_cnt1_r     <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            if (gnt0_s && (gnt_cnt0_r != 32'hFFFF_FFFF)) begin
                gnt_cnt0_r <= gnt_cnt0_r + 32'd1;
            end else begin
                gnt_cnt0_r <= gnt_cnt0_r;
            end
            if (gnt1_s && (gnt_cnt1_r != 32'hFFFF_FFFF)) begin
                gnt_cnt1_r <= gnt_cnt1_r + 32'd1;
            end else begin
                gnt_cnt1_r <= gnt_cnt1_r;
            end
            if (conflict_s && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign gnt_cnt0_o     = gnt_cnt0_r;
    assign gnt_cnt1_o     = gnt_cnt1_r;
    assign conflict_cnt_o = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 1024 x 32 behavioural memory
// (combinational read, write on posedge). Inputs change 1 time unit after a
// rising edge. Combinational grants are checked 1 time unit later, and
// registered responses are checked 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = 10'd0;
    logic [31:0] pre_data = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .addr0_i(addr0), .we0_i(we0), .wdata0_i(wdata0), .lock0_i(lock0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0), .err0_o(err0),
        .req1_i(req1), .addr1_i(addr1), .we1_i(we1), .wdata1_i(wdata1), .lock1_i(lock1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1), .err1_o(err1),
`ifdef DMEM_ARB_STATS_EN
        .gnt_cnt0_o(gnt_cnt0), .gnt_cnt1_o(gnt_cnt1), .conflict_cnt_o(conflict_cnt),
`endif
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // behavioural single-port memory with a bench-side preload path
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic drop_all;
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; wdata1 = 32'd0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        preload(10'd5,    32'hDEAD_BEEF);
        preload(10'd6,    32'h0000_0606);
        preload(10'd0,    32'hA5A5_0000);
        preload(10'd21,   32'h0000_2121);
        preload(10'd1023, 32'h0BAD_CAFE);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; req1 = 1'b1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b expected 0000", {rvalid0, rvalid1, err0, err1}); end
        checks++; if ({rdata0, rdata1} !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1}); end
        drop_all();
        addr0 = 32'd0;
        rst = 1'b1;
        #1;
        checks++; if ({mem_addr, mem_we, mem_wdata} !== 65'd0) begin errors++; $display("FAIL idle_bus: got %h expected 0", {mem_addr, mem_we, mem_wdata}); end
        tick();
    endtask

    task automatic test_round_robin;
        req0 = 1'b1; addr0 = 32'd5; req1 = 1'b1; addr1 = 32'd6;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b", i, {gnt0, gnt1}); end
            if (i % 2 == 1) begin
                checks++; if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rr_resp0[%0d]: got %b %h expected 10 deadbeef", i, {rvalid0, rvalid1}, rdata0); end
            end else if (i > 0) begin
                checks++; if ({rvalid0, rvalid1, rdata1} !== {2'b01, 32'h0000_0606}) begin errors++; $display("FAIL rr_resp1[%0d]: got %b %h expected 01 00000606", i, {rvalid0, rvalid1}, rdata1); end
            end
            tick();
        end
        drop_all();
        #1;
        checks++; if ({rvalid0, rvalid1, rdata1} !== {2'b01, 32'h0000_0606}) begin errors++; $display("FAIL rr_last_resp: got %b %h", {rvalid0, rvalid1}, rdata1); end
`ifdef DMEM_ARB_STATS_EN
        checks++; if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== {32'd5, 32'd5, 32'd10}) begin errors++; $display("FAIL stats: got %0d %0d %0d expected 5 5 10", gnt_cnt0, gnt_cnt1, conflict_cnt); end
`endif
        tick();
    endtask

    task automatic test_read;
        req0 = 1'b1; addr0 = 32'd5; we0 = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1, mem_we, mem_addr} !== {3'b100, 32'd5}) begin errors++; $display("FAIL read_cmd: got %b %h expected 100 5", {gnt0, gnt1, mem_we}, mem_addr); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid0, rvalid1, err0, rdata0} !== {3'b100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL read_resp: got %b %h expected 100 deadbeef", {rvalid0, rvalid1, err0}, rdata0); end
        tick();
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL read_pulse: got %b expected 0", rvalid0); end
    endtask

    task automatic test_burst;
        // port 1 wins (last was port 0) and locks for MAX_BURST = 4 beats
        req0 = 1'b1; addr0 = 32'd5; req1 = 1'b1; addr1 = 32'd6; lock1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL burst_beat[%0d]: got %b expected 01", k, {gnt0, gnt1}); end
            tick();
        end
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL burst_release: got %b expected 10", {gnt0, gnt1}); end
        tick();
        lock1 = 1'b0; req1 = 1'b0;
        req0 = 1'b0;
        #1;
        checks++; if ({rvalid0, rdata0} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL burst_p0_resp: got %b %h", rvalid0, rdata0); end
        tick();
        // early release: lock dropped after two beats
        req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL lock_beat1: got %b expected 01", {gnt0, gnt1}); end
        tick();
        lock1 = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL lock_beat2: got %b expected 01", {gnt0, gnt1}); end
        tick();
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL lock_exit: got %b expected 10", {gnt0, gnt1}); end
        tick();
        drop_all();
        tick();
    endtask

    task automatic test_write_read;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd10; wdata0 = 32'h1234_5678;
        #1;
        checks++; if ({gnt0, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'd10, 32'h1234_5678}) begin errors++; $display("FAIL wr_cmd: got %b %h %h", {gnt0, mem_we}, mem_addr, mem_wdata); end
        tick();
        drop_all();
        req1 = 1'b1; addr1 = 32'd10;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL wr_rd_gnt: got %b expected 01", {gnt0, gnt1}); end
        checks++; if ({rvalid0, err0, rdata0} !== {2'b10, 32'd0}) begin errors++; $display("FAIL wr_ack: got %b %h expected 10 0", {rvalid0, err0}, rdata0); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid1, err1, rdata1} !== {2'b10, 32'h1234_5678}) begin errors++; $display("FAIL wr_rd_data: got %b %h expected 10 12345678", {rvalid1, err1}, rdata1); end
        tick();
    endtask

    task automatic test_out_of_range;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1024; wdata0 = 32'hFFFF_FFFF;
        #1;
        checks++; if ({gnt0, mem_we, mem_addr} !== {2'b10, 32'd0}) begin errors++; $display("FAIL oor_cmd: got %b %h expected 10 0", {gnt0, mem_we}, mem_addr); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid0, err0, rdata0} !== {2'b11, 32'd0}) begin errors++; $display("FAIL oor_resp: got %b %h expected 11 0", {rvalid0, err0}, rdata0); end
        checks++; if (mem[0] !== 32'hA5A5_0000) begin errors++; $display("FAIL oor_mem0: got %h expected a5a50000", mem[0]); end
        tick();
        req0 = 1'b1; addr0 = 32'd1023;
        #1;
        checks++; if (mem_addr !== 32'd1023) begin errors++; $display("FAIL edge_addr: got %h expected 3ff", mem_addr); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid0, err0, rdata0} !== {2'b10, 32'h0BAD_CAFE}) begin errors++; $display("FAIL edge_resp: got %b %h expected 10 0badcafe", {rvalid0, err0}, rdata0); end
        tick();
        req1 = 1'b1; addr1 = 32'hFFFF_FFFF;
        #1;
        checks++; if ({gnt1, mem_addr} !== {1'b1, 32'd0}) begin errors++; $display("FAIL oor1_cmd: got %b %h expected 1 0", gnt1, mem_addr); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid1, err1, rdata1} !== {2'b11, 32'd0}) begin errors++; $display("FAIL oor1_resp: got %b %h expected 11 0", {rvalid1, err1}, rdata1); end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'h1111_1111;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL rb_beat1: got %b expected 01", {gnt0, gnt1}); end
        tick();
        addr1 = 32'd21; wdata1 = 32'h2222_2222;
        #1;
        checks++; if ({gnt1, mem_we} !== 2'b11) begin errors++; $display("FAIL rb_beat2: got %b expected 11", {gnt1, mem_we}); end
        rst = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b00000) begin errors++; $display("FAIL rb_drop: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, mem_we}); end
        tick();
        checks++; if ({mem[20], mem[21]} !== {32'h1111_1111, 32'h0000_2121}) begin errors++; $display("FAIL rb_mem: got %h %h expected 11111111 00002121", mem[20], mem[21]); end
        req0 = 1'b1; addr0 = 32'd5;
        rst = 1'b1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rb_first: got %b expected 10", {gnt0, gnt1}); end
        tick();
        drop_all();
        #1;
        checks++; if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rb_resp: got %b %h", {rvalid0, rvalid1}, rdata0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_burst();
        test_write_read();
        test_out_of_range();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
